ext_sync_sysref_align: RTL
==========================

# ext_sync_sysref_align

Aligns the board-level external sync request to the JESD SYSREF grid of the quad-MxFE design. It sits directly upstream of the `ext_sync` input of the test harness and MxFE link cores. An asynchronous `ext_sync` request is synchronized into `device_clk` and arms the block. The next SYSREF rising edge, plus a programmable delay, then fires a single-cycle `sync_out` pulse, so every converter and link sees the sync at a deterministic LMFC-related position.

## Interface
- `SYNC_STAGES`, 3: synchronizer depth for `ext_sync`; legal values are 2 to 4.
- `DELAY_WIDTH`, 8: width of `sync_delay`.
- `TIMEOUT_CYCLES`, 1024: maximum number of cycles spent in ARMED waiting for SYSREF; must be at least 2.
- `CNT_WIDTH`, 16: width of `sync_count`.
- `device_clk`  in  1  sole clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ext_sync`  in  1  asynchronous sync request; level input, and only rising edges act.
- `sysref`  in  1  SYSREF, already synchronous to `device_clk`.
- `sync_delay`  in  DELAY_WIDTH  cycles from the SYSREF edge to `sync_out`; sampled on the SYSREF edge.
- `sync_out`  out  1  single-cycle aligned sync pulse; registered.
- `armed`  out  1  high while in ARMED.
- `busy`  out  1  high in any state other than IDLE.
- `timeout`  out  1  single-cycle pulse when ARMED expires without a SYSREF edge.
- `sync_count`  out  CNT_WIDTH  number of `sync_out` pulses issued; wraps.

## Operation
- Synchronizer: a flop chain of SYNC_STAGES flops, followed by one flop `req_d`. The request edge is `req_edge` = chain output AND NOT `req_d`.
- SYSREF edge: `sysref` is registered once into `sysref_d`. The edge is `sr_edge` = `sysref` AND NOT `sysref_d`.
- The FSM has states IDLE, ARMED, DELAY and FIRE.
  - IDLE: on `req_edge`, go to ARMED and clear the timeout counter.
  - ARMED: the timeout counter increments every cycle.
    - On `sr_edge`, go to DELAY and load the delay counter with `sync_delay`.
    - Otherwise, when the counter equals TIMEOUT_CYCLES-1, pulse `timeout` and go to IDLE.
    - If `sr_edge` and expiry occur in the same cycle, the edge wins: no `timeout`, go to DELAY.
  - DELAY: the delay counter decrements. At zero, go to FIRE. A loaded value of 0 goes straight to FIRE on the next edge.
  - FIRE: `sync_out` is high for exactly this one cycle, `sync_count` increments (wrapping to 0 from all-ones), then go to IDLE.
- A `req_edge` in any state other than IDLE is dropped and is not queued. A SYSREF edge outside ARMED is ignored.
- `sync_delay` changing after it is sampled has no effect on the pulse in flight.
- `armed` is high only in ARMED. `busy` is high in ARMED, DELAY and FIRE.

## Timing
- Reset values: `sync_out`, `armed`, `busy` and `timeout` are all 0; `sync_count` is 0; state is IDLE; the synchronizer, `req_d`, `sysref_d` and both counters are 0.
- Reset applies immediately and asynchronously. A sequence cut off by reset is abandoned.
- If `ext_sync` is high when reset is released, it is treated as a new rising edge and arms the block SYNC_STAGES+1 cycles later.
- Arm latency: `ext_sync` is first sampled high at edge k. The chain output is high at edge k+SYNC_STAGES-1 and `armed` rises at edge k+SYNC_STAGES.
- Fire latency: `sr_edge` is true in the cycle ending at edge t, with state ARMED at edge t. The FSM moves to DELAY at edge t and `sync_out` is high from edge t+1+D to edge t+2+D, where D is the sampled `sync_delay`.
- A SYSREF edge in the very cycle in which the state becomes ARMED is not seen. Only edges evaluated while already in ARMED count.
- Throughput: the next request can be accepted in the cycle after FIRE, so `req_edge` may arm at the edge immediately following FIRE.
- Timeout: `timeout` pulses at the TIMEOUT_CYCLES-th edge spent in ARMED, and `armed` falls on the same edge.
- Maximum time busy per request is TIMEOUT_CYCLES, or 1 + D + 1 cycles after the SYSREF edge.

## Test plan
- Basic alignment (defaults, `sync_delay`=0): SYSREF is a 1-high/15-low pattern and `ext_sync` pulses at 22 us.
  - Expect exactly one `sync_out` one cycle after the first SYSREF edge that follows `armed`.
  - Expect `sync_count`=1.
- Programmable delay: `sync_delay`=5 -> `sync_out` lands 6 cycles after the SYSREF edge. Change `sync_delay` to 9 during DELAY -> the fire cycle is unchanged.
- Timeout (TIMEOUT_CYCLES=16): hold SYSREF low and pulse `ext_sync`.
  - Expect `armed` high for 16 cycles, then one `timeout` pulse.
  - Expect no `sync_out` and `sync_count` unchanged.
  - Then drive SYSREF as in the basic test and re-pulse `ext_sync` -> normal fire.
- Drops and boundary: pulse `ext_sync` twice, 3 cycles apart -> one `sync_out` only.
  - Make `sr_edge` coincide with timeout expiry -> `sync_out` fires and `timeout` stays 0.
  - Preload `sync_count` near its limit using CNT_WIDTH=4 and 16 sequences -> `sync_count` wraps to 0.
- Reset mid-operation: assert `resetn` low during DELAY -> all outputs are 0 immediately, with no `sync_out` afterwards.
  - Release reset with `ext_sync` held high -> `armed` rises 4 cycles later (SYNC_STAGES=3).
- Two-event scenario: `ext_sync` pulses at 22 us and again 50 us later -> `sync_count`=2, and each `sync_out` is at the same SYSREF phase.

Source files
------------

// File: rtl/ext_sync_sysref_align.sv
// ext_sync_sysref_align
//
// Aligns an asynchronous board-level sync request to the JESD SYSREF grid.
// A rising edge on ext_sync is synchronised into device_clk and arms the
// block. The next SYSREF rising edge seen while armed starts a programmable
// delay. When the delay ends, sync_out fires as a single-cycle pulse, so
// every downstream converter and link receives the sync at the same
// LMFC-related position.
//
// Ports:
//   device_clk  sole clock; all logic runs on its rising edge
//   resetn      asynchronous active-low reset
//   ext_sync    asynchronous sync request (level input; only rising edges act)
//   sysref      SYSREF, already synchronous to device_clk
//   sync_delay  cycles from the SYSREF edge to sync_out, captured on that edge
//   sync_out    single-cycle aligned sync pulse (registered)
//   armed       high while waiting for SYSREF
//   busy        high whenever a request is in progress
//   timeout     single-cycle pulse when the wait for SYSREF expires
//   sync_count  number of sync_out pulses issued; wraps around
module ext_sync_sysref_align #(
  parameter int SYNC_STAGES    = 3,
  parameter int DELAY_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   device_clk,
  input  logic                   resetn,
  input  logic                   ext_sync,
  input  logic                   sysref,
  input  logic [DELAY_WIDTH-1:0] sync_delay,
  output logic                   sync_out,
  output logic                   armed,
  output logic                   busy,
  output logic                   timeout,
  output logic [CNT_WIDTH-1:0]   sync_count
);

  // Wide enough to hold TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES is at least 2).
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_FIRE  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain_r;
  logic                   req_d_r;
  logic                   sysref_d_r;
  state_t                 state_r;
  logic [TMO_W-1:0]       tmo_cnt_r;
  logic [DELAY_WIDTH-1:0] dly_cnt_r;
  logic                   sync_out_r;
  logic                   armed_r;
  logic                   busy_r;
  logic                   timeout_r;
  logic [CNT_WIDTH-1:0]   sync_count_r;

  state_t                 state_nxt_s;
  logic [TMO_W-1:0]       tmo_cnt_nxt_s;
  logic [DELAY_WIDTH-1:0] dly_cnt_nxt_s;
  logic                   timeout_nxt_s;
  logic                   req_edge_s;
  logic                   sr_edge_s;

  // The chain and req_d clear on reset, so a request held high through
  // reset release is seen as a fresh rising edge.
  assign req_edge_s = sync_chain_r[SYNC_STAGES-1] & ~req_d_r;
  assign sr_edge_s  = sysref & ~sysref_d_r;

  // Request synchroniser, request edge delay flop and SYSREF edge delay flop.
  always_ff @(posedge device_clk or negedge resetn) begin
    if (!resetn) begin
      sync_chain_r <= {SYNC_STAGES{1'b0}};
      req_d_r      <= 1'b0;
      sysref_d_r   <= 1'b0;
    end else begin
      sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], ext_sync};
      req_d_r      <= sync_chain_r[SYNC_STAGES-1];
      sysref_d_r   <= sysref;
    end
  end

  // Next-state logic. Requests outside IDLE and SYSREF edges outside ARMED
  // fall through untouched. In ARMED a SYSREF edge takes priority over expiry.
  always_comb begin
    state_nxt_s   = state_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    dly_cnt_nxt_s = dly_cnt_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_edge_s) begin
          state_nxt_s   = ST_ARMED;
          tmo_cnt_nxt_s = {TMO_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
        if (sr_edge_s) begin
          state_nxt_s   = ST_DELAY;
          dly_cnt_nxt_s = sync_delay;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s   = ST_IDLE;
          timeout_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_DELAY: begin
        if (dly_cnt_r == {DELAY_WIDTH{1'b0}}) begin
          state_nxt_s = ST_FIRE;
        end else begin
          state_nxt_s   = ST_DELAY;
          dly_cnt_nxt_s = dly_cnt_r - DELAY_WIDTH'(1);
        end
      end
      ST_FIRE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge device_clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= {TMO_W{1'b0}};
      dly_cnt_r <= {DELAY_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      dly_cnt_r <= dly_cnt_nxt_s;
    end
  end

  // Output registers. They are decoded from the next state, so each one
  // changes on the same edge as the state it reflects.
  always_ff @(posedge device_clk or negedge resetn) begin
    if (!resetn) begin
      sync_out_r   <= 1'b0;
      armed_r      <= 1'b0;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
      sync_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      sync_out_r <= (state_nxt_s == ST_FIRE);
      armed_r    <= (state_nxt_s == ST_ARMED);
      busy_r     <= (state_nxt_s != ST_IDLE);
      timeout_r  <= timeout_nxt_s;
      if (state_nxt_s == ST_FIRE) begin
        sync_count_r <= sync_count_r + CNT_WIDTH'(1);
      end else begin
        sync_count_r <= sync_count_r;
      end
    end
  end

  assign sync_out   = sync_out_r;
  assign armed      = armed_r;
  assign busy       = busy_r;
  assign timeout    = timeout_r;
  assign sync_count = sync_count_r;

endmodule
